// File: rtl/switch_seq_pkg.sv
// switch_seq_pkg: shared state encoding, default timing and counter sizing for switch_sequencer
package switch_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_e;
  localparam int HOLD_DEF = 200000;
  localparam int GAP_DEF = 900000;
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2((hold > gap ? hold : gap) + 1);
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter; expired pulses for one cycle when a loaded count runs out
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt_q;
  logic         run_q;
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= value;
      run_q <= 1'b1;
    end else if (run_q) begin
      cnt_q <= cnt_q - W'(|cnt_q);
      run_q <= |cnt_q;
    end
  assign expired = run_q && cnt_q == '0;
endmodule

// File: rtl/switch_sequencer.sv
// switch_sequencer: stores switch patterns and replays each as sw setup, timed write hold, timed gap
module switch_sequencer
  import switch_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = HOLD_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [3:0]               load_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [3:0]               sw,
  output logic                     write,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] slot
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  state_e          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      sw_q, sw_d, fwd0;
  logic [AW-1:0]   slot_q, slot_d, nxt_idx;
  logic [AW:0]     len_q, len_d;
  logic            loop_q, loop_d, done_q, done_d, last, t_load, t_exp;
  logic [CW-1:0]   t_val;
  seq_timer #(.W(CW)) u_timer (
    .clk(sysclk), .rst(rst), .load(t_load), .value(t_val), .expired(t_exp)
  );
  // a load to slot 0 in the start cycle must be visible to the first SETUP
  assign fwd0 = (load && load_addr == '0) ? load_data : mem_q[0];
  assign last = (AW+1)'({1'b0, slot_q} + 1'b1) == len_q;
  assign nxt_idx = last ? '0 : slot_q + 1'b1;
  always_comb begin
    state_d = state_q;
    sw_d = sw_q;
    slot_d = slot_q;
    len_d = len_q;
    loop_d = loop_q;
    done_d = 1'b0;
    t_load = 1'b0;
    t_val = CW'(HOLD_CYCLES - 1);
    if (stop && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start && !stop) begin
          if (len == '0) done_d = 1'b1;
          else begin
            state_d = SETUP;
            len_d = len;
            loop_d = loop;
            slot_d = '0;
            sw_d = fwd0;
          end
        end
        SETUP: begin
          state_d = HOLD;
          t_load = 1'b1;
        end
        HOLD: if (t_exp) begin
          state_d = GAP;
          t_load = 1'b1;
          t_val = CW'(GAP_CYCLES - 1);
        end
        GAP: if (t_exp) begin
          if (!last || loop_q) begin
            state_d = SETUP;
            slot_d = nxt_idx;
            sw_d = mem_q[nxt_idx];
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge sysclk)
    if (rst) begin
      state_q <= IDLE;
      sw_q <= '0;
      slot_q <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q <= sw_d;
      slot_q <= slot_d;
      len_q <= len_d;
      loop_q <= loop_d;
      done_q <= done_d;
    end
  always_ff @(posedge sysclk)
    if (rst) mem_q <= '{default: '0};
    else if (load && state_q == IDLE) mem_q[load_addr] <= load_data;
  assign sw = sw_q;
  assign slot = slot_q;
  assign done = done_q;
  assign write = state_q == HOLD;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: random patterns replayed against a step/phase arithmetic model of playback
module tb_switch_sequencer;
  localparam int H = 4, G = 6, P = 1 + H + G;
  logic clk = 1'b0;
  logic rst, load, loop, start, stop, write, busy, done;
  logic [1:0] load_addr, slot;
  logic [3:0] load_data, sw;
  logic [2:0] len;
  logic [3:0] mem_m [4];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  switch_sequencer #(.DEPTH(4), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .sysclk(clk), .rst(rst), .load(load), .load_addr(load_addr), .load_data(load_data),
    .len(len), .loop(loop), .start(start), .stop(stop), .sw(sw), .write(write),
    .busy(busy), .done(done), .slot(slot)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] esw, input logic ew, input logic eb,
                         input logic ed, input logic [1:0] es);
    chk({tag, ".sw"}, 32'(sw), 32'(esw));
    chk({tag, ".write"}, 32'(write), 32'(ew));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".slot"}, 32'(slot), 32'(es));
  endtask
  task automatic do_load(input int a, input logic [3:0] d);
    load = 1'b1;
    load_addr = 2'(a);
    load_data = d;
    step();
    load = 1'b0;
    mem_m[a] = d;
  endtask
  // playback cycle k (k=0 is the first cycle after start) is step k/P, phase k%P
  task automatic play(input string tag, input int ln, input bit lp, input int ncyc, input int stop_at,
                      input int inj_at, input bit ld0, input logic [3:0] ld0_val);
    int es, ph;
    logic eb, ew, ed;
    start = 1'b1;
    len = 3'(ln);
    loop = lp;
    if (ld0) begin
      load = 1'b1;
      load_addr = 2'd0;
      load_data = ld0_val;
      mem_m[0] = ld0_val;
    end
    step();
    start = 1'b0;
    load = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (!lp && k >= ln * P) begin
        eb = 1'b0; ew = 1'b0; ed = (k == ln * P); es = ln - 1;
      end else begin
        es = (k / P) % ln;
        ph = k % P;
        eb = 1'b1; ew = (ph >= 1 && ph <= H); ed = 1'b0;
      end
      chk_all(tag, mem_m[es], ew, eb, ed, 2'(es));
      if (k == stop_at) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_all({tag, ".stop"}, mem_m[es], 1'b0, 1'b0, 1'b0, 2'(es));
        return;
      end
      if (k == inj_at) begin
        load = 1'b1;
        load_addr = 2'd1;
        load_data = 4'hF;
        start = 1'b1;
        len = 3'd1;
      end
      step();
      load = 1'b0;
      start = 1'b0;
    end
  endtask
  initial begin
    int ln, sa;
    bit lp;
    rst = 1'b1; load = 1'b0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    load_addr = '0; load_data = '0; len = '0;
    for (int i = 0; i < 4; i++) mem_m[i] = 4'h0;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    do_load(0, 4'h1);
    do_load(1, 4'h2);
    play("basic", 2, 1'b0, 24, -1, -1, 1'b0, 4'h0);
    for (int a = 0; a < 4; a++) do_load(a, 4'($urandom));
    play("loop", 4, 1'b1, 60, 40, -1, 1'b0, 4'h0);
    play("busy_ignore", 2, 1'b0, 24, -1, 2, 1'b0, 4'h0);
    len = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("len0", mem_m[1], 1'b0, 1'b0, 1'b1, 2'd1);
    step();
    chk_all("len0_after", mem_m[1], 1'b0, 1'b0, 1'b0, 2'd1);
    len = 3'd2;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk_all("start_stop", mem_m[1], 1'b0, 1'b0, 1'b0, 2'd1);
    step();
    chk_all("start_stop2", mem_m[1], 1'b0, 1'b0, 1'b0, 2'd1);
    play("load_start", 1, 1'b0, 14, -1, -1, 1'b1, 4'($urandom) | 4'h8);
    len = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("midhold.write", 32'(write), 32'd1);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mem_m[i] = 4'h0;
    chk_all("rst_mid2", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    play("mem_cleared", 4, 1'b0, 46, -1, -1, 1'b0, 4'h0);
    repeat (8) begin
      for (int a = 0; a < 4; a++) do_load(a, 4'($urandom));
      ln = int'($urandom_range(1, 4));
      lp = 1'($urandom_range(0, 1));
      sa = lp ? int'($urandom_range(0, 50)) : ($urandom_range(0, 1) == 1 ? int'($urandom_range(0, ln * P - 1)) : -1);
      play("random", ln, lp, lp ? 60 : ln * P + 2, sa, -1, 1'b0, 4'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_sequencer.md
# switch_sequencer

Scripted driver for the `switch` block. It stores up to DEPTH 4-bit switch patterns and plays them back in order. For each pattern it drives the `sw1..sw4` inputs, then a timed `write` strobe, then a timed gap, replacing manual operation of the switches and write line. It sits between host/button logic and `switch`, and runs from the same 50 MHz `sysclk`.

## Interface
Parameters:
- `DEPTH`, 8, number of pattern slots; power of two, ≥2.
- `HOLD_CYCLES`, 200000, cycles `write` stays high per step (4 ms at 50 MHz); ≥1.
- `GAP_CYCLES`, 900000, cycles `write` stays low after each hold (18 ms); ≥1.

Ports:
- `sysclk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `load`, in, 1: write `load_data` into slot `load_addr`. Honoured only when `busy`=0.
- `load_addr`, in, clog2(DEPTH): slot index for `load`.
- `load_data`, in, 4: pattern; bit0→sw1 … bit3→sw4.
- `len`, in, clog2(DEPTH)+1: number of slots to play. Sampled on an accepted `start`; legal range 0..DEPTH.
- `loop`, in, 1: sampled on `start`. When 1, playback wraps from slot len-1 to slot 0 until `stop`.
- `start`, in, 1: begin playback. Honoured only when `busy`=0.
- `stop`, in, 1: abort playback.
- `sw`, out, 4: drives `switch` inputs sw1..sw4.
- `write`, out, 1: drives `switch.write`.
- `busy`, out, 1: playback in progress.
- `done`, out, 1: one-cycle pulse when a non-looping playback completes.
- `slot`, out, clog2(DEPTH): index of the current or last-played slot.

## Operation
- FSM states: IDLE, SETUP, HOLD, GAP.
- Reset:
  - FSM goes to IDLE.
  - `sw`, `write`, `busy`, `done` and `slot` all go to 0.
  - Pattern memory is cleared to 0.
- IDLE behaviour:
  - `start`=1 with `len`≠0: latch `len` and `loop`, set `slot`=0, go to SETUP.
  - `start`=1 with `len`=0: stay in IDLE and pulse `done` the next cycle.
- SETUP (1 cycle): `sw`←mem[`slot`], `write`=0. Next state is HOLD.
- HOLD: `write`=1 for exactly HOLD_CYCLES cycles; `sw` stays stable. Next state is GAP.
- GAP: `write`=0 for GAP_CYCLES cycles.
  - If `slot`<len-1: increment `slot` and go to SETUP.
  - Else if `loop`=1: set `slot`=0 and go to SETUP.
  - Else: go to IDLE and pulse `done`.
- `sw` holds its last value in IDLE; it is never cleared except by reset.
- `stop` in any non-IDLE state:
  - Next cycle is IDLE with `write`=0 and `busy`=0.
  - `done` is not pulsed.
  - `sw` and `slot` are retained.
- Priority rules:
  - `rst` > `stop` > `start`.
  - `start` and `stop` asserted together in IDLE: no action.
  - `load` or `start` while busy: ignored; memory is unchanged.
  - `load` and `start` in the same IDLE cycle: the write lands first, so slot 0 read in SETUP sees the new data.
- Counters:
  - Hold/gap down-counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
  - `slot` increments modulo DEPTH; with `len`=DEPTH the wrap to 0 is natural.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- `start` sampled at edge N gives:
  - `busy`=1 and `sw`=mem[0] from edge N+1 (SETUP).
  - `write`=1 from edge N+2.
- `sw` is stable ≥1 cycle before every `write` rising edge and throughout HOLD.
- Step period is 1+HOLD_CYCLES+GAP_CYCLES cycles.
- Non-looping playback:
  - `busy` is high for len·(1+HOLD+GAP) cycles.
  - `done` is high for the single cycle after `busy` falls, and `busy`=0 during it.
- `stop` sampled at edge N gives `write`=0 and `busy`=0 at edge N+1.
- `rst` mid-playback gives all outputs 0 at the next edge.

## Structure
- Package `switch_seq_pkg` holds:
  - the state enum (IDLE/SETUP/HOLD/GAP);
  - default HOLD/GAP constants;
  - a function for the counter width.
- Sub-module `seq_timer`: a loadable down-counter with `load`, `value` and a one-cycle `expired` output. It is instantiated once and reloaded with HOLD or GAP.
- Pattern memory: DEPTH×4 register array inside `switch_sequencer`.

## Test plan
Parameters DEPTH=4, HOLD=4, GAP=6 unless noted.
- Reset check: assert `rst` for 2 cycles mid-HOLD → `sw`, `write`, `busy`, `done` and `slot` all 0 at the next edge; memory reads back 0.
- Basic playback:
  - Stimulus: load {0:4'h1, 1:4'h2}, start with len=2, loop=0.
  - Expect: `sw`=1 then 2; `write` high for exactly 4 cycles per step, 1 cycle after the `sw` change.
  - Expect: `busy` high for 22 cycles, then `done` for 1 cycle.
- Looping:
  - Stimulus: len=4, loop=1, no stop.
  - Expect: `slot` sequence 0,1,2,3,0,1…; `done` never pulses.
  - Stimulus: `stop` during GAP.
  - Expect: next cycle `busy`=0, `write`=0, `sw` unchanged.
- Ignore-while-busy:
  - Stimulus: `load` slot 1=4'hF and `start` during HOLD of slot 0.
  - Expect: slot 1 still plays its old value; the timing period is unaltered.
- Edge cases:
  - len=0 → `done` next cycle, `busy` stays 0.
  - `start`+`stop` same cycle → no action.
  - `load` and `start` same cycle → the new slot 0 value is played.
- Default parameters: start with len=1 → `write` high for 200000 cycles, `busy` for 1100001 cycles total.
